// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream receive path.
package stream_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, FIN} state_t;

  localparam int unsigned DEF_DATA_W = 32;

  // Pointer carries one extra wrap bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always on dout.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W + 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_receive.sv
// Receives one source burst into a FWFT FIFO, hands words to the compute side
// and strobes get_fin once the last-tagged word has been popped.
module stream_receive
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              get_valid,
  output logic [DATA_W-1:0] get_data,
  input  logic              get_ready,
  output logic              get_fin,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  state_t        state;
  state_t        state_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [DATA_W:0] head;

  // s_ready depends only on state and full, so there is no path from s_valid.
  assign s_ready   = (state == RECV) && !full;
  assign get_valid = !empty;
  assign push      = s_valid && s_ready;
  assign pop       = get_valid && get_ready;
  assign get_data  = head[DATA_W-1:0];
  assign get_fin   = (state == FIN);
  assign busy      = (state != IDLE);

  stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({s_last, s_data}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RECV;
      RECV:  if (push && s_last) state_nxt = DRAIN;
      DRAIN: if (pop && head[DATA_W]) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
    end else if ((state == IDLE) && start) begin
      word_count <= '0;
    end else if (push && (word_count != '1)) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_receive.sv
// Directed bench for stream_receive with hand-computed expectations.
module tb_stream_receive;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        get_valid;
  logic [31:0] get_data;
  logic        get_ready = 1'b0;
  logic        get_fin;
  logic        busy;
  logic [15:0] word_count;

  int unsigned tests = 0;
  int unsigned failed = 0;

  stream_receive #(
    .DATA_W (32),
    .DEPTH  (8),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .get_valid  (get_valid),
    .get_data   (get_data),
    .get_ready  (get_ready),
    .get_fin    (get_fin),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned push_idx;
    int unsigned pop_idx;
    logic        fin_exp;
    logic        fin_seen;

    // reset state
    #2;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_get_valid", 32'(get_valid), 0);
    check("rst_get_fin", 32'(get_fin), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_word_count", 32'(word_count), 0);
    tick();
    rst = 1'b1;
    tick();

    // 4-word burst, get_ready held high
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    check("t1_s_ready", 32'(s_ready), 1);
    check("t1_count0", 32'(word_count), 0);
    get_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h10 + 32'(i);
      s_last  = (i == 3);
      tick();
      check($sformatf("t1_valid%0d", i), 32'(get_valid), 1);
      check($sformatf("t1_data%0d", i), get_data, 32'h10 + 32'(i));
      check($sformatf("t1_fin_early%0d", i), 32'(get_fin), 0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t1_drain_s_ready", 32'(s_ready), 0);
    tick();
    check("t1_fin", 32'(get_fin), 1);
    check("t1_fin_empty", 32'(get_valid), 0);
    check("t1_fin_busy", 32'(busy), 1);
    check("t1_count", 32'(word_count), 4);
    tick();
    check("t1_fin_drop", 32'(get_fin), 0);
    check("t1_busy_drop", 32'(busy), 0);
    get_ready = 1'b0;

    // 10 words into an 8-deep FIFO with the sink stalled
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h20 + 32'(i);
      s_last  = 1'b0;
      tick();
    end
    check("t2_full_s_ready", 32'(s_ready), 0);
    check("t2_count8", 32'(word_count), 8);
    check("t2_head", get_data, 32'h20);
    s_data = 32'h28;
    tick();
    check("t2_hold_count", 32'(word_count), 8);
    get_ready = 1'b1;
    check("t2_no_bypass", 32'(s_ready), 0);
    push_idx = 8;
    pop_idx  = 0;
    fin_exp  = 1'b0;
    fin_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin_seen; cyc++) begin
      if (get_valid && get_ready) begin
        check($sformatf("t2_data%0d", pop_idx), get_data, 32'h20 + 32'(pop_idx));
        fin_exp = (pop_idx == 9);
        pop_idx++;
      end else begin
        fin_exp = 1'b0;
      end
      if (s_valid && s_ready) push_idx++;
      tick();
      if (push_idx < 10) begin
        s_valid = 1'b1;
        s_data  = 32'h20 + 32'(push_idx);
        s_last  = (push_idx == 9);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      check("t2_fin_timing", 32'(get_fin), 32'(fin_exp));
      fin_seen = get_fin;
    end
    check("t2_fin_seen", 32'(fin_seen), 1);
    check("t2_popped", pop_idx, 10);
    check("t2_count", 32'(word_count), 10);
    get_ready = 1'b0;
    tick();

    // one-word burst, then start while in DRAIN
    start = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hAB;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t3_s_ready", 32'(s_ready), 0);
    check("t3_data", get_data, 32'hAB);
    check("t3_count", 32'(word_count), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_count_kept", 32'(word_count), 1);
    check("t4_still_busy", 32'(busy), 1);
    check("t4_still_valid", 32'(get_valid), 1);
    check("t4_no_fin", 32'(get_fin), 0);
    get_ready = 1'b1;
    tick();
    get_ready = 1'b0;
    check("t3_fin", 32'(get_fin), 1);
    tick();
    check("t3_idle", 32'(busy), 0);

    // source words offered in IDLE are not taken
    s_valid = 1'b1;
    s_data  = 32'h55;
    tick();
    tick();
    check("t5_s_ready", 32'(s_ready), 0);
    check("t5_get_valid", 32'(get_valid), 0);
    check("t5_count", 32'(word_count), 1);
    s_valid = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("t4_count_clear", 32'(word_count), 0);

    // reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h30 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    check("t6_count3", 32'(word_count), 3);
    check("t6_valid", 32'(get_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_s_ready", 32'(s_ready), 0);
    check("t6_rst_get_valid", 32'(get_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_count", 32'(word_count), 0);
    check("t6_rst_fin", 32'(get_fin), 0);
    tick();
    rst = 1'b1;
    get_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_post_valid%0d", i), 32'(get_valid), 0);
      check($sformatf("t6_post_fin%0d", i), 32'(get_fin), 0);
      check($sformatf("t6_post_busy%0d", i), 32'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
